// File: rtl/audio_pkg.sv
// Shared audio constants: PCM sample width, default DAC MSB index and the
// midscale (zero) code of the excess-2^MSBI DAC word.
package audio_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int DEFAULT_MSBI = 16;

    localparam logic [DEFAULT_MSBI:0] MIDSCALE = 17'h10000;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO. Occupancy is kept in a counter one bit wider
// than the pointers, so that a full FIFO and an empty FIFO are never confused.
module sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers PCM samples and feeds a sigma-delta DAC with an excess-2^MSBI word.
// Each sample taken on a tick is approached through a short linear ramp.
module dac_sample_feeder
    import audio_pkg::*;
#(
    parameter int MSBI      = DEFAULT_MSBI,
    parameter int DEPTH     = 4,
    parameter int RAMP_LOG2 = 3
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                in_ready,
    input  logic                tick,
    input  logic [2:0]          atten,
    output logic [MSBI:0]       DACin,
    output logic                underrun
);

    localparam logic [MSBI:0] MID      = (MSBI+1)'(1) << MSBI;
    localparam int            CW       = RAMP_LOG2 + 1;
    localparam logic [CW-1:0] RAMP_LEN = CW'(1) << RAMP_LOG2;

    logic [SAMPLE_W-1:0]        head;
    logic                       full;
    logic                       empty;
    logic                       pop;
    logic signed [SAMPLE_W-1:0] scaled;
    logic [MSBI:0]              target_next;
    logic signed [MSBI+1:0]     diff;
    logic [MSBI:0]              step_next;
    logic [MSBI:0]              target;
    logic [MSBI:0]              step;
    logic [CW-1:0]              cnt;

    assign in_ready = RESET_N && !full;
    assign pop      = tick && !empty;

    sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (in_valid && in_ready),
        .wdata   (in_data),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty)
    );

    // The step is taken one bit wider than the DAC word so that full-scale
    // swings keep their sign; after the shift the result fits again.
    always_comb begin
        scaled      = $signed(head) >>> atten;
        target_next = (MSBI+1)'(scaled) + MID;
        diff        = $signed({1'b0, target_next}) - $signed({1'b0, DACin});
        step_next   = (MSBI+1)'(diff >>> RAMP_LOG2);
    end

    // A pop always restarts the ramp from the present DACin; the last ramp
    // edge loads the exact target so truncation of the step never accumulates.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            DACin    <= MID;
            target   <= MID;
            step     <= '0;
            cnt      <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= tick && empty;
            if (pop) begin
                target <= target_next;
                step   <= step_next;
                cnt    <= RAMP_LEN;
            end else if (cnt > CW'(1)) begin
                DACin <= DACin + step;
                cnt   <= cnt - CW'(1);
            end else if (cnt == CW'(1)) begin
                DACin <= target;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed bench: stimulus pushes the expected post-edge outputs into a queue
// and a negedge monitor pops one entry per cycle and compares.
module tb_dac_sample_feeder;
    import audio_pkg::*;

    localparam int X   = -1;
    localparam int MID = int'(MIDSCALE);

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        tick = 1'b0;
    logic [2:0]  atten = '0;
    logic        in_ready;
    logic [16:0] DACin;
    logic        underrun;

    typedef struct {
        string name;
        int    dac;
        int    ur;
        int    rdy;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    dac_sample_feeder dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tick     (tick),
        .atten    (atten),
        .DACin    (DACin),
        .underrun (underrun)
    );

    task automatic checkOutput(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // One call is one clock: drive after the negedge, expect after the posedge.
    task automatic applyStimulus(input bit rstn, input bit v, input logic [15:0] d,
                                 input bit t, input logic [2:0] a, input string nm,
                                 input int edac, input int eur, input int erdy);
        exp_t e;
        @(negedge CLK);
        #1;
        RESET_N  = rstn;
        in_valid = v;
        in_data  = d;
        tick     = t;
        atten    = a;
        e.name = nm;
        e.dac  = edac;
        e.ur   = eur;
        e.rdy  = erdy;
        expq.push_back(e);
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            if (e.dac >= 0) checkOutput({e.name, ".DACin"}, int'(DACin), e.dac);
            if (e.ur >= 0)  checkOutput({e.name, ".underrun"}, int'(underrun), e.ur);
            if (e.rdy >= 0) checkOutput({e.name, ".in_ready"}, int'(in_ready), e.rdy);
        end
    end

    initial begin : stimulus
        int drain [3];
        drain = '{'h11111, 'h12222, 'h13333};

        repeat (3) applyStimulus(0, 0, 16'h0, 0, 0, "reset", MID, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 0, "release", 'h10000, 0, 1);

        // Positive sample, no attenuation: step 0x800 per edge.
        applyStimulus(1, 1, 16'h4000, 0, 0, "push_pos", 'h10000, 0, 1);
        applyStimulus(1, 0, 16'h0, 1, 0, "pop_pos", 'h10000, 0, 1);
        for (int k = 1; k <= 8; k++)
            applyStimulus(1, 0, 16'h0, 0, 0, "ramp_pos", (k < 8) ? ('h10000 + 'h800 * k) : 'h14000, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, "hold_pos", 'h14000, 0, 1);

        // Most negative sample halved; atten returns to 0 right after the pop.
        applyStimulus(1, 1, 16'h8000, 0, 0, "push_neg", 'h14000, 0, 1);
        applyStimulus(1, 0, 16'h0, 1, 1, "pop_neg", 'h14000, 0, 1);
        for (int k = 1; k <= 8; k++)
            applyStimulus(1, 0, 16'h0, 0, 0, "ramp_neg", (k < 8) ? ('h14000 - 'h1000 * k) : 'h0C000, 0, 1);

        // Tick on empty FIFO, then tick with a simultaneous push (no bypass).
        applyStimulus(1, 0, 16'h0, 1, 0, "urun", 'h0C000, 1, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, "urun_end", 'h0C000, 0, 1);
        applyStimulus(1, 1, 16'h1234, 1, 0, "nobypass", 'h0C000, 1, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, "nobypass_h1", 'h0C000, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, "nobypass_h2", 'h0C000, 0, 1);

        // Fill to DEPTH, then pop and push together while full.
        applyStimulus(1, 1, 16'h1111, 0, 0, "fill2", 'h0C000, 0, 1);
        applyStimulus(1, 1, 16'h2222, 0, 0, "fill3", 'h0C000, 0, 1);
        applyStimulus(1, 1, 16'h3333, 0, 0, "fill4", 'h0C000, 0, 0);
        applyStimulus(1, 1, 16'h7777, 0, 0, "full_hold", 'h0C000, 0, 0);
        applyStimulus(1, 1, 16'h7777, 1, 0, "pop_at_full", 'h0C000, 0, 1);
        for (int k = 1; k <= 8; k++)
            applyStimulus(1, 0, 16'h0, 0, 0, "ramp_1234", (k == 1) ? 'h0CA46 : ((k == 8) ? 'h11234 : X), 0, 1);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1, 0, 16'h0, 1, 0, "drain_pop", X, 0, 1);
            for (int k = 1; k <= 8; k++)
                applyStimulus(1, 0, 16'h0, 0, 0, "drain_ramp", (k == 8) ? drain[s] : X, 0, 1);
        end
        applyStimulus(1, 0, 16'h0, 1, 0, "refused_push", 'h13333, 1, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, "refused_end", 'h13333, 0, 1);

        // Reset one edge into a ramp: no stale step afterwards.
        applyStimulus(1, 1, 16'h7000, 0, 0, "push_7000", 'h13333, 0, 1);
        applyStimulus(1, 0, 16'h0, 1, 0, "pop_7000", 'h13333, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, "ramp_7000", 'h13ACC, 0, 1);
        applyStimulus(0, 0, 16'h0, 0, 0, "rst_mid", MID, 0, 0);
        for (int k = 0; k < 10; k++)
            applyStimulus(1, 0, 16'h0, 0, 0, "post_rst", 'h10000, 0, 1);

        // Second pop three cycles into a ramp restarts from the current DACin.
        applyStimulus(1, 1, 16'h4000, 0, 0, "push_a", 'h10000, 0, 1);
        applyStimulus(1, 1, 16'h0000, 0, 0, "push_b", 'h10000, 0, 1);
        applyStimulus(1, 0, 16'h0, 1, 0, "pop_a", 'h10000, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, "ramp_a1", 'h10800, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, "ramp_a2", 'h11000, 0, 1);
        applyStimulus(1, 0, 16'h0, 1, 0, "pop_b", 'h11000, 0, 1);
        for (int k = 1; k <= 8; k++)
            applyStimulus(1, 0, 16'h0, 0, 0, "ramp_b", (k < 8) ? ('h11000 - 'h200 * k) : 'h10000, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 0, "hold_b", 'h10000, 0, 1);

        @(negedge CLK);
        #1;
        checkOutput("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
